xoodyak_ise_issue: RTL and testbench

XOODYAK_ISE_ISSUE -- requirements
Module: xoodyak_ise_issue

---
 rtl/xoodyak_ise_issue_pkg.sv | 57 +++++
 rtl/xoodyak_ise_issue_if.sv | 28 ++
 rtl/xoodyak_ise_issue_rv64b.sv | 44 ++++
 rtl/xoodyak_ise_issue.sv | 112 +++++++++++
 tb/tb_xoodyak_ise_issue.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xoodyak_ise_issue_pkg.sv
// Shared constants and types for the Xoodyak ISE issue stage.
// Contents:
//   ISE_OPCODE        major opcode carrying the Xoodyak custom instructions
//   F3_ROLI/ROLIW/ANDN funct3 selectors for the three supported operations
//   FIFO_DEPTH        result buffer depth (two entries)
//   op_sel_t          one-hot operation select plus illegal-encoding flag
//   rsp_entry_t       one buffered result {rd, idx, err}
//   decode_op()       instruction word -> op_sel_t
//   sext32()          sign-extend a 32-bit value to 64 bits
package xoodyak_ise_issue_pkg;

   localparam logic [6:0]  ISE_OPCODE = 7'b0101011;
   localparam logic [2:0]  F3_ROLI    = 3'b000;
   localparam logic [2:0]  F3_ROLIW   = 3'b001;
   localparam logic [2:0]  F3_ANDN    = 3'b010;
   localparam int unsigned FIFO_DEPTH = 2;

   typedef logic [1:0] occ_t;
   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_FULL  = 2'(FIFO_DEPTH);

   typedef struct packed {
      logic roli;
      logic roliw;
      logic andn;
      logic err;
   } op_sel_t;

   typedef struct packed {
      logic [63:0] rd;
      logic [4:0]  idx;
      logic        err;
   } rsp_entry_t;

   // Anything that is not the ISE opcode with a known funct3 is flagged and
   // selects no operation, so the ISE output is never trusted for it.
   function automatic op_sel_t decode_op(input logic [31:0] instr);
      op_sel_t sel;
      sel = '0;
      if (instr[6:0] != ISE_OPCODE) begin
         sel.err = 1'b1;
      end else begin
         case (instr[14:12])
            F3_ROLI:  sel.roli  = 1'b1;
            F3_ROLIW: sel.roliw = 1'b1;
            F3_ANDN:  sel.andn  = 1'b1;
            default:  sel.err   = 1'b1;
         endcase
      end
      return sel;
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/xoodyak_ise_issue_if.sv
// Request/response bus between the core pipeline and the ISE issue stage.
// Request side : req_valid, req_ready, req_instr[31:0], req_rs1[63:0], req_rs2[63:0]
// Response side: rsp_valid, rsp_ready, rsp_rd[63:0], rsp_idx[4:0], rsp_err
// master = pipeline (offers requests, consumes results); slave = issue stage.
interface xoodyak_ise_issue_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr;
   logic [63:0] req_rs1;
   logic [63:0] req_rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rd;
   logic [4:0]  rsp_idx;
   logic        rsp_err;

   modport master (
      output req_valid, req_instr, req_rs1, req_rs2, rsp_ready,
      input  req_ready, rsp_valid, rsp_rd, rsp_idx, rsp_err
   );

   modport slave (
      input  req_valid, req_instr, req_rs1, req_rs2, rsp_ready,
      output req_ready, rsp_valid, rsp_rd, rsp_idx, rsp_err
   );

endinterface

// File: rtl/xoodyak_ise_issue_rv64b.sv
// Combinational RV64 bit-manipulation unit used by the Xoodyak ISE.
// Ports:
//   rs1, rs2  [63:0] in  source operands
//   imm       [4:0]  in  rotate amount
//   op_roli          in  rd = rs1 rotated left by imm (64-bit)
//   op_roliw         in  rd = {32'h0, rs1[31:0] rotated left by imm}
//   op_andn          in  rd = rs1 & ~rs2
//   rd        [63:0] out result, zero when no op is selected
module xoodyak_ise_issue_rv64b (
   input  logic [63:0] rs1,
   input  logic [63:0] rs2,
   input  logic [4:0]  imm,
   input  logic        op_roli,
   input  logic        op_roliw,
   input  logic        op_andn,
   output logic [63:0] rd
);

   logic [63:0] roli_s;
   logic [31:0] roliw_s;
   logic [63:0] andn_s;

   // Datapaths; a right shift by the full width yields zero, so imm=0 is exact.
   always_comb begin
      roli_s  = (rs1 << imm) | (rs1 >> (7'd64 - {2'b00, imm}));
      roliw_s = (rs1[31:0] << imm) | (rs1[31:0] >> (6'd32 - {1'b0, imm}));
      andn_s  = rs1 & ~rs2;
   end

   // Result select; selects are one-hot from the decoder.
   always_comb begin
      rd = 64'd0;
      if (op_roli) begin
         rd = roli_s;
      end else if (op_roliw) begin
         rd = {32'd0, roliw_s};
      end else if (op_andn) begin
         rd = andn_s;
      end else begin
         rd = 64'd0;
      end
   end

endmodule

// File: rtl/xoodyak_ise_issue.sv
// Issue stage for the Xoodyak custom instructions (roli, roliw, andn).
// A request is decoded and executed combinationally in its accept cycle and
// the result is parked in a 2-entry FIFO until writeback consumes it.
// Ports:
//   g_clk      in   clock, all state on the rising edge
//   g_rst      in   asynchronous active-high reset
//   flush      in   discard every buffered result
//   bus        slave side of xoodyak_ise_issue_if (request/response handshakes)
//   op_count   out  [31:0] accepted-request counter, wraps
module xoodyak_ise_issue
   import xoodyak_ise_issue_pkg::*;
(
   input  logic                 g_clk,
   input  logic                 g_rst,
   input  logic                 flush,
   xoodyak_ise_issue_if.slave   bus,
   output logic [31:0]          op_count
);

   op_sel_t     sel_s;
   logic [63:0] ise_rd_s;
   rsp_entry_t  entry_s;
   rsp_entry_t  fifo_r [FIFO_DEPTH];
   logic        wr_ptr_r;
   logic        rd_ptr_r;
   occ_t        occ_r;
   logic        push_s;
   logic        pop_s;
   logic [31:0] op_count_r;
   logic [31:0] op_count_nxt_s;

   assign sel_s = decode_op(bus.req_instr);

   xoodyak_ise_issue_rv64b u_rv64b (
      .rs1      (bus.req_rs1),
      .rs2      (bus.req_rs2),
      .imm      (bus.req_instr[24:20]),
      .op_roli  (sel_s.roli),
      .op_roliw (sel_s.roliw),
      .op_andn  (sel_s.andn),
      .rd       (ise_rd_s)
   );

   // Build the FIFO entry; roliw is widened here, illegal encodings force rd=0.
   always_comb begin
      entry_s     = '0;
      entry_s.idx = bus.req_instr[11:7];
      entry_s.err = sel_s.err;
      if (sel_s.err) begin
         entry_s.rd = 64'd0;
      end else if (sel_s.roliw) begin
         entry_s.rd = sext32(ise_rd_s[31:0]);
      end else begin
         entry_s.rd = ise_rd_s;
      end
   end

   // ready/valid come only from occupancy, so rsp_ready never reaches req_ready.
   assign bus.req_ready = (occ_r != OCC_FULL);
   assign bus.rsp_valid = (occ_r != OCC_EMPTY);

   // flush overrides both handshakes in its cycle.
   assign push_s = bus.req_valid & bus.req_ready & ~flush;
   assign pop_s  = bus.rsp_valid & bus.rsp_ready & ~flush;

   assign op_count_nxt_s = op_count_r + {31'd0, push_s};

   // FIFO storage, pointers and occupancy; with two entries a pointer is one
   // bit and advancing it is a toggle.
   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_r[i] <= '0;
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         occ_r    <= OCC_EMPTY;
      end else if (flush) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         occ_r    <= OCC_EMPTY;
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= entry_s;
            wr_ptr_r         <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Accepted-request counter; wraps naturally at 32 bits.
   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         op_count_r <= 32'd0;
      end else begin
         op_count_r <= op_count_nxt_s;
      end
   end

   assign bus.rsp_rd  = fifo_r[rd_ptr_r].rd;
   assign bus.rsp_idx = fifo_r[rd_ptr_r].idx;
   assign bus.rsp_err = fifo_r[rd_ptr_r].err;
   assign op_count    = op_count_r;

endmodule

// File: tb/tb_xoodyak_ise_issue.sv
// Self-checking bench for xoodyak_ise_issue: a vector table streamed through
// with a scoreboard queue, plus hand-written backpressure, flush, counter-wrap
// and asynchronous-reset sequences.
module tb_xoodyak_ise_issue;

   localparam logic [6:0] OPC = 7'b0101011;
   localparam logic [6:0] BAD = 7'b0110011;

   typedef struct packed {
      logic [63:0] rd;
      logic [4:0]  idx;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] rs1;
      logic [63:0] rs2;
      exp_t        exp;
   } vec_t;

   logic        g_clk;
   logic        g_rst;
   logic        flush;
   logic [31:0] op_count;

   xoodyak_ise_issue_if bus ();

   xoodyak_ise_issue dut (
      .g_clk    (g_clk),
      .g_rst    (g_rst),
      .flush    (flush),
      .bus      (bus),
      .op_count (op_count)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_ticks = 0;
   exp_t        sb[$];
   exp_t        cur_exp;
   logic [31:0] exp_count = 32'd0;
   bit          accepted;
   vec_t        vt[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic [2:0] f3, input logic [4:0] sh,
                       input logic [4:0] rdi, input logic [6:0] opc,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] rd, input logic err);
      vt[i].instr = {7'd0, sh, 5'd0, f3, rdi, opc};
      vt[i].rs1   = rs1;
      vt[i].rs2   = rs2;
      vt[i].exp   = '{rd: rd, idx: rdi, err: err};
   endtask

   task automatic drive(input vec_t v);
      bus.req_valid = 1'b1;
      bus.req_instr = v.instr;
      bus.req_rs1   = v.rs1;
      bus.req_rs2   = v.rs2;
      cur_exp       = v.exp;
   endtask

   // One clock: check the DUT against the model, update the model for this
   // edge's handshakes, then step to 1 time unit past the rising edge.
   task automatic tick();
      bit do_pop;
      bit do_push;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(sb.size() != 0));
      chk("req_ready", 64'(bus.req_ready), 64'(sb.size() < 2));
      chk("op_count", 64'(op_count), 64'(exp_count));
      if (sb.size() != 0) begin
         chk("head_rd", bus.rsp_rd, sb[0].rd);
         chk("head_idx", 64'(bus.rsp_idx), 64'(sb[0].idx));
         chk("head_err", 64'(bus.rsp_err), 64'(sb[0].err));
      end
      do_pop   = (sb.size() != 0) && bus.rsp_ready && !flush;
      do_push  = bus.req_valid && (sb.size() < 2) && !flush;
      accepted = do_push;
      if (flush) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            sb.push_back(cur_exp);
            exp_count++;
         end
      end
      n_ticks++;
      @(posedge g_clk);
      #1;
   endtask

   task automatic send(input vec_t v);
      int guard = 0;
      drive(v);
      accepted = 1'b0;
      while (!accepted && guard < 20) begin
         tick();
         guard++;
      end
      if (!accepted) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got no accept, required accept within 20 cycles");
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      while (sb.size() != 0 && guard < 20) begin
         tick();
         guard++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d entries left, required 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cnt0;
      int          t0;

      setv(0,  3'd0, 5'd1,  5'd1,  OPC, 64'h8000000000000001, 64'h0, 64'h0000000000000003, 1'b0);
      setv(1,  3'd1, 5'd1,  5'd2,  OPC, 64'h00000000C0000000, 64'h0, 64'hFFFFFFFF80000001, 1'b0);
      setv(2,  3'd2, 5'd0,  5'd3,  OPC, 64'h00000000000000FF, 64'h0F, 64'h00000000000000F0, 1'b0);
      setv(3,  3'd7, 5'd0,  5'd4,  OPC, 64'h0000000000001234, 64'h0, 64'h0, 1'b1);
      setv(4,  3'd0, 5'd1,  5'd5,  BAD, 64'h0000000000000001, 64'h0, 64'h0, 1'b1);
      setv(5,  3'd0, 5'd0,  5'd6,  OPC, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF, 1'b0);
      setv(6,  3'd0, 5'd31, 5'd7,  OPC, 64'h0000000000000001, 64'h0, 64'h0000000080000000, 1'b0);
      setv(7,  3'd1, 5'd0,  5'd8,  OPC, 64'hFFFFFFFF12345678, 64'h0, 64'h0000000012345678, 1'b0);
      setv(8,  3'd1, 5'd4,  5'd9,  OPC, 64'h0000000087654321, 64'h0, 64'h0000000076543218, 1'b0);
      setv(9,  3'd2, 5'd5,  5'd10, OPC, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0);
      setv(10, 3'd3, 5'd2,  5'd11, OPC, 64'h5, 64'h5, 64'h0, 1'b1);
      setv(11, 3'd0, 5'd4,  5'd31, OPC, 64'hF000000000000000, 64'h0, 64'h000000000000000F, 1'b0);
      setv(12, 3'd0, 5'd16, 5'd0,  OPC, 64'h00000000FFFF0000, 64'h0, 64'h0000FFFF00000000, 1'b0);

      g_rst = 1'b0; flush = 1'b0;
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.req_instr = 32'd0; bus.req_rs1 = 64'd0; bus.req_rs2 = 64'd0;
      #1 g_rst = 1'b1;
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_rd", bus.rsp_rd, 64'd0);
      chk("rst_rsp_idx", 64'(bus.rsp_idx), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      repeat (2) @(posedge g_clk);
      #1 g_rst = 1'b0;

      // Streaming the table with writeback always ready: one accept per cycle.
      bus.rsp_ready = 1'b1;
      t0 = n_ticks;
      for (int i = 0; i < 13; i++) send(vt[i]);
      chk("throughput_cycles", 64'(n_ticks - t0), 64'd13);
      drain();

      // Backpressure: third request stalls, results drain in order.
      bus.rsp_ready = 1'b0;
      cnt0 = exp_count;
      send(vt[1]);
      send(vt[3]);
      drive(vt[6]);
      repeat (3) tick();
      chk("bp_accepted", 64'(op_count - cnt0), 64'd2);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      drain();

      // Illegal funct3 still counts as an accepted request.
      cnt0 = exp_count;
      send(vt[3]);
      drain();
      chk("illegal_count", 64'(op_count), 64'(cnt0 + 32'd1));

      // Flush while full, with a push and pop offered in the same cycle.
      bus.rsp_ready = 1'b0;
      send(vt[0]);
      send(vt[2]);
      cnt0 = exp_count;
      drive(vt[5]);
      flush = 1'b1;
      bus.rsp_ready = 1'b1;
      tick();
      flush = 1'b0;
      bus.req_valid = 1'b0;
      chk("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("flush_op_count", 64'(op_count), 64'(cnt0));
      tick();

      // Counter wrap: preload the counter, then one accept must roll it to 0.
      force dut.op_count_nxt_s = 32'hFFFF_FFFF;
      @(posedge g_clk);
      #1;
      release dut.op_count_nxt_s;
      exp_count = 32'hFFFF_FFFF;
      chk("wrap_preload", 64'(op_count), 64'h0000_0000_FFFF_FFFF);
      send(vt[9]);
      chk("wrap_zero", 64'(op_count), 64'd0);
      drain();

      // Asynchronous reset mid-stream clears outputs with no clock edge.
      bus.rsp_ready = 1'b0;
      send(vt[11]);
      send(vt[8]);
      drive(vt[0]);
      #2 g_rst = 1'b1;
      #1;
      chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("arst_rsp_rd", bus.rsp_rd, 64'd0);
      chk("arst_rsp_idx", 64'(bus.rsp_idx), 64'd0);
      chk("arst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("arst_op_count", 64'(op_count), 64'd0);
      sb.delete();
      exp_count = 32'd0;
      @(posedge g_clk);
      #1 g_rst = 1'b0;
      tick();
      chk("post_reset_accept", 64'(accepted), 64'd1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
